// File: rtl/spm_pkg.sv
// spm_pkg: shared constants for the stored-program machine control unit.
//   - 4-bit opcode constants
//   - 4-bit FSM state encodings
//   - Bus_1 / Bus_2 source select codes
//   - instruction-class flag struct produced by spm_opcode_decode
package spm_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_RD   = 4'd5;
  localparam logic [3:0] OP_WR   = 4'd6;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_BRZ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_FET1 = 4'd1,
    ST_FET2 = 4'd2,
    ST_DEC  = 4'd3,
    ST_EX1  = 4'd4,
    ST_RD1  = 4'd5,
    ST_RD2  = 4'd6,
    ST_WR1  = 4'd7,
    ST_WR2  = 4'd8,
    ST_BR1  = 4'd9,
    ST_BR2  = 4'd10,
    ST_HALT = 4'd11
  } state_e;

  // Bus_1 sources: 0..3 are R0..R3, 4 is the program counter.
  localparam logic [2:0] SEL1_PC   = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef struct packed {
    logic alu2;     // ADD, SUB, AND: two-operand, needs Reg_Y then EX1
    logic alu1;     // NOT: single operand, completes in DEC
    logic mem_rd;   // RD
    logic mem_wr;   // WR
    logic branch;   // BR
    logic cond;     // BRZ
    logic halt;     // HALT
    logic illegal;  // opcodes 9..14
  } op_class_t;

endpackage

// File: rtl/spm_control_unit_if.sv
// spm_control_unit_if: command/status bundle between the control unit and
// the datapath/memory.
//   instruction[7:0] IR contents ([7:4] opcode, [3:2] src, [1:0] dest)
//   zero             registered ALU zero flag
//   Load_R[3:0]      one-hot register load enables (R3..R0)
//   Load_PC/Inc_PC   program counter load / increment
//   Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  register load strobes
//   Sel_Bus_1[2:0], Sel_Bus_2[1:0]  bus source selects
//   write            memory write strobe
//   state[3:0]       current sequencer state (debug)
// master: control unit side; slave: datapath side.
interface spm_control_unit_if;
  logic [7:0] instruction;
  logic       zero;
  logic [3:0] Load_R;
  logic       Load_PC;
  logic       Inc_PC;
  logic       Load_IR;
  logic       Load_Add_R;
  logic       Load_Reg_Y;
  logic       Load_Reg_Z;
  logic [2:0] Sel_Bus_1;
  logic [1:0] Sel_Bus_2;
  logic       write;
  logic [3:0] state;

  modport master (
    input  instruction, zero,
    output Load_R, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y,
           Load_Reg_Z, Sel_Bus_1, Sel_Bus_2, write, state
  );

  modport slave (
    output instruction, zero,
    input  Load_R, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y,
           Load_Reg_Z, Sel_Bus_1, Sel_Bus_2, write, state
  );
endinterface

// File: rtl/spm_opcode_decode.sv
// spm_opcode_decode: combinational opcode -> instruction-class flags.
//   opcode[3:0] in : IR[7:4]
//   cls         out: op_class_t, at most one flag set; NOP sets none
import spm_pkg::*;

module spm_opcode_decode (
  input  logic [3:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_NOP:                 ;
      OP_ADD, OP_SUB, OP_AND: cls.alu2    = 1'b1;
      OP_NOT:                 cls.alu1    = 1'b1;
      OP_RD:                  cls.mem_rd  = 1'b1;
      OP_WR:                  cls.mem_wr  = 1'b1;
      OP_BR:                  cls.branch  = 1'b1;
      OP_BRZ:                 cls.cond    = 1'b1;
      OP_HALT:                cls.halt    = 1'b1;
      default:                cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/spm_control_unit.sv
// spm_control_unit: fetch/decode/execute sequencer for the 8-bit RISC
// stored-program machine. The state register is the only storage; every
// strobe is combinational from state, the IR fields and the zero flag.
//   clk  in : clock
//   rst  in : asynchronous active-low reset (state -> IDLE, all strobes 0)
//   cu       : spm_control_unit_if.master (IR/zero in, strobes/selects out)
// Build option: define SPM_CU_ILLEGAL_HALT_EN to send illegal opcodes
// (9..14) to HALT; otherwise they execute as NOP.
//
// state | meaning
// IDLE  | after reset, no strobes
// FET1  | PC -> address register
// FET2  | memory -> IR, PC++
// DEC   | decode; single-cycle ops finish here
// EX1   | two-operand ALU result -> R[dest], Reg_Z
// RD1   | operand address byte -> address register, PC++
// RD2   | memory -> R[dest]
// WR1   | operand address byte -> address register, PC++
// WR2   | R[src] -> memory
// BR1   | branch target address -> address register
// BR2   | memory -> PC
// HALT  | parked until reset
import spm_pkg::*;

module spm_control_unit (
  input logic                clk,
  input logic                rst,
  spm_control_unit_if.master cu
);

  state_e     state_q, state_d;
  op_class_t  cls;
  logic [1:0] src, dest;
  logic [3:0] dest_onehot;

  logic [3:0] load_r;
  logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
  logic [2:0] sel_bus_1;
  logic [1:0] sel_bus_2;
  logic       write_en;

  assign src         = cu.instruction[3:2];
  assign dest        = cu.instruction[1:0];
  assign dest_onehot = 4'b0001 << dest;

  spm_opcode_decode u_decode (
    .opcode (cu.instruction[7:4]),
    .cls    (cls)
  );

  always_comb begin
    state_d    = state_q;
    load_r     = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    sel_bus_1  = 3'd0;
    sel_bus_2  = SEL2_ALU;
    write_en   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FET1;

      ST_FET1: begin
        sel_bus_1  = SEL1_PC;
        sel_bus_2  = SEL2_BUS1;
        load_add_r = 1'b1;
        state_d    = ST_FET2;
      end

      ST_FET2: begin
        sel_bus_2 = SEL2_MEM;
        load_ir   = 1'b1;
        inc_pc    = 1'b1;
        state_d   = ST_DEC;
      end

      ST_DEC: begin
        if (cls.alu2) begin
          sel_bus_1  = {1'b0, src};
          load_reg_y = 1'b1;
          state_d    = ST_EX1;
        end else if (cls.alu1) begin
          sel_bus_1  = {1'b0, src};
          sel_bus_2  = SEL2_ALU;
          load_reg_z = 1'b1;
          load_r     = dest_onehot;
          state_d    = ST_FET1;
        end else if (cls.mem_rd || cls.mem_wr || cls.branch || (cls.cond && cu.zero)) begin
          // All operand-byte instructions first point the address register
          // at the byte following the opcode.
          sel_bus_1  = SEL1_PC;
          sel_bus_2  = SEL2_BUS1;
          load_add_r = 1'b1;
          if (cls.mem_rd)      state_d = ST_RD1;
          else if (cls.mem_wr) state_d = ST_WR1;
          else                 state_d = ST_BR1;
        end else if (cls.cond) begin
          // Branch not taken: step the PC over the unused target byte.
          inc_pc  = 1'b1;
          state_d = ST_FET1;
        end else if (cls.halt) begin
          state_d = ST_HALT;
        end else if (cls.illegal) begin
`ifdef SPM_CU_ILLEGAL_HALT_EN
          state_d = ST_HALT;
`else
          state_d = ST_FET1;
`endif
        end else begin
          state_d = ST_FET1;
        end
      end

      ST_EX1: begin
        sel_bus_1  = {1'b0, dest};
        sel_bus_2  = SEL2_ALU;
        load_reg_z = 1'b1;
        load_r     = dest_onehot;
        state_d    = ST_FET1;
      end

      ST_RD1, ST_WR1: begin
        sel_bus_2  = SEL2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = (state_q == ST_RD1) ? ST_RD2 : ST_WR2;
      end

      ST_RD2: begin
        sel_bus_2 = SEL2_MEM;
        load_r    = dest_onehot;
        state_d   = ST_FET1;
      end

      ST_WR2: begin
        sel_bus_1 = {1'b0, src};
        write_en  = 1'b1;
        state_d   = ST_FET1;
      end

      ST_BR1: begin
        sel_bus_2  = SEL2_MEM;
        load_add_r = 1'b1;
        state_d    = ST_BR2;
      end

      ST_BR2: begin
        sel_bus_2 = SEL2_MEM;
        load_pc   = 1'b1;
        state_d   = ST_FET1;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  assign cu.Load_R     = load_r;
  assign cu.Load_PC    = load_pc;
  assign cu.Inc_PC     = inc_pc;
  assign cu.Load_IR    = load_ir;
  assign cu.Load_Add_R = load_add_r;
  assign cu.Load_Reg_Y = load_reg_y;
  assign cu.Load_Reg_Z = load_reg_z;
  assign cu.Sel_Bus_1  = sel_bus_1;
  assign cu.Sel_Bus_2  = sel_bus_2;
  assign cu.write      = write_en;
  assign cu.state      = state_q;

endmodule

// File: tb/tb_spm_control_unit.sv
// Testbench for spm_control_unit: directed instructions from the ISA
// description followed by random instruction bytes, each checked cycle by
// cycle against a micro-step table built per instruction class.
module tb_spm_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] r;
    logic       pc;
    logic       inc;
    logic       ir;
    logic       ar;
    logic       y;
    logic       z;
    logic [2:0] s1;
    logic [1:0] s2;
    logic       wr;
  } step_t;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_PC   = 7'b1000000;
  localparam logic [6:0] F_INC  = 7'b0100000;
  localparam logic [6:0] F_IR   = 7'b0010000;
  localparam logic [6:0] F_AR   = 7'b0001000;
  localparam logic [6:0] F_Y    = 7'b0000100;
  localparam logic [6:0] F_Z    = 7'b0000010;
  localparam logic [6:0] F_WR   = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  step_t      exp_q[$];
  logic [3:0] nxt_exp;
  int         inc_exp;

  spm_control_unit_if bus();

  spm_control_unit dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [3:0] st, input logic [2:0] s1,
                               input logic [1:0] s2, input logic [3:0] r,
                               input logic [6:0] fl);
    step_t s;
    s.st = st;
    s.r  = r;
    {s.pc, s.inc, s.ir, s.ar, s.y, s.z, s.wr} = fl;
    s.s1 = s1;
    s.s2 = s2;
    return s;
  endfunction

  function automatic step_t obs_now();
    step_t s;
    s.st  = bus.state;
    s.r   = bus.Load_R;
    s.pc  = bus.Load_PC;
    s.inc = bus.Inc_PC;
    s.ir  = bus.Load_IR;
    s.ar  = bus.Load_Add_R;
    s.y   = bus.Load_Reg_Y;
    s.z   = bus.Load_Reg_Z;
    s.s1  = bus.Sel_Bus_1;
    s.s2  = bus.Sel_Bus_2;
    s.wr  = bus.write;
    return s;
  endfunction

  // Micro-step table of one instruction, FET1 through its last cycle, plus
  // the state it should land in and how many PC increments it issues.
  function automatic void build(input logic [7:0] ins, input logic z);
    logic [3:0] op;
    logic [2:0] src, dst;
    logic [3:0] rbit;
    op   = ins[7:4];
    src  = {1'b0, ins[3:2]};
    dst  = {1'b0, ins[1:0]};
    rbit = 4'b0001 << ins[1:0];
    exp_q.delete();
    exp_q.push_back(mk(4'd1, 3'd4, 2'd1, 4'd0, F_AR));
    exp_q.push_back(mk(4'd2, 3'd0, 2'd2, 4'd0, F_IR | F_INC));
    nxt_exp = 4'd1;
    inc_exp = 1;
    case (op)
      4'd1, 4'd2, 4'd3: begin
        exp_q.push_back(mk(4'd3, src, 2'd0, 4'd0, F_Y));
        exp_q.push_back(mk(4'd4, dst, 2'd0, rbit, F_Z));
      end
      4'd4: exp_q.push_back(mk(4'd3, src, 2'd0, rbit, F_Z));
      4'd5: begin
        exp_q.push_back(mk(4'd3, 3'd4, 2'd1, 4'd0, F_AR));
        exp_q.push_back(mk(4'd5, 3'd0, 2'd2, 4'd0, F_AR | F_INC));
        exp_q.push_back(mk(4'd6, 3'd0, 2'd2, rbit, F_NONE));
        inc_exp = 2;
      end
      4'd6: begin
        exp_q.push_back(mk(4'd3, 3'd4, 2'd1, 4'd0, F_AR));
        exp_q.push_back(mk(4'd7, 3'd0, 2'd2, 4'd0, F_AR | F_INC));
        exp_q.push_back(mk(4'd8, src, 2'd0, 4'd0, F_WR));
        inc_exp = 2;
      end
      4'd7, 4'd8: begin
        if (op == 4'd7 || z) begin
          exp_q.push_back(mk(4'd3, 3'd4, 2'd1, 4'd0, F_AR));
          exp_q.push_back(mk(4'd9, 3'd0, 2'd2, 4'd0, F_AR));
          exp_q.push_back(mk(4'd10, 3'd0, 2'd2, 4'd0, F_PC));
        end else begin
          exp_q.push_back(mk(4'd3, 3'd0, 2'd0, 4'd0, F_INC));
          inc_exp = 2;
        end
      end
      4'd15: begin
        exp_q.push_back(mk(4'd3, 3'd0, 2'd0, 4'd0, F_NONE));
        nxt_exp = 4'd11;
      end
      4'd0: exp_q.push_back(mk(4'd3, 3'd0, 2'd0, 4'd0, F_NONE));
      default: begin
        exp_q.push_back(mk(4'd3, 3'd0, 2'd0, 4'd0, F_NONE));
`ifdef SPM_CU_ILLEGAL_HALT_EN
        nxt_exp = 4'd11;
`endif
      end
    endcase
  endfunction

  task automatic check(input string tag, input step_t o, input step_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] e);
    checks++;
    assert (bus.state === e) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state, e);
    end
  endtask

  // Called at a falling edge with the DUT in FET1.
  task automatic run_instr(input logic [7:0] ins, input logic z, input string tag);
    int    n_inc;
    step_t o;
    n_inc = 0;
    bus.instruction = ins;
    bus.zero        = z;
    build(ins, z);
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      o = obs_now();
      if (o.inc) n_inc++;
      check($sformatf("%s step%0d", tag, i), o, exp_q[i]);
    end
    @(negedge clk);
    check_state({tag, " next"}, nxt_exp);
    checks++;
    assert (n_inc == inc_exp) else begin
      errors++;
      $error("FAIL %s inc_pc_count observed=%0d expected=%0d", tag, n_inc, inc_exp);
    end
  endtask

  // Called at a falling edge; asserts rst mid-cycle and re-syncs to FET1.
  task automatic reset_to_fet1(input string tag);
    #2 rst = 1'b0;
    #1 check({tag, " async_reset"}, obs_now(), '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_state({tag, " restart"}, 4'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      assert (!(bus.Load_PC && bus.Inc_PC) && ($countones(bus.Load_R) <= 1) &&
              !(bus.write && (bus.Load_R != 4'd0))) else begin
        errors++;
        $error("FAIL invariant pc=%b inc=%b load_r=%b write=%b",
               bus.Load_PC, bus.Inc_PC, bus.Load_R, bus.write);
      end
    end
  end

  initial begin
    logic [7:0] ins;
    logic       z;
    bus.instruction = 8'h00;
    bus.zero        = 1'b0;

    @(negedge clk);
    check("reset_idle", obs_now(), '0);
    rst = 1'b1;
    @(negedge clk);

    run_instr(8'h16, 1'b0, "add");
    run_instr(8'h80, 1'b0, "brz_nt");
    run_instr(8'h80, 1'b1, "brz_t");
    run_instr(8'h6C, 1'b0, "wr");
    run_instr(8'h5B, 1'b1, "rd");
    run_instr(8'h4E, 1'b0, "not");
    run_instr(8'h73, 1'b0, "br");
    run_instr(8'h00, 1'b1, "nop");
    run_instr(8'h90, 1'b0, "illegal");
    if (nxt_exp == 4'd11) reset_to_fet1("illegal");

    // Abort a WR in WR1: nothing may be left asserted once rst falls.
    bus.instruction = 8'h6C;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_state("abort in_wr1", 4'd7);
    reset_to_fet1("abort");

    for (int k = 0; k < 60; k++) begin
      ins = 8'($urandom);
      z   = 1'($urandom_range(0, 1));
      run_instr(ins, z, $sformatf("rand%0d_%h_z%0d", k, ins, z));
      if (nxt_exp == 4'd11) reset_to_fet1($sformatf("rand%0d", k));
    end

    run_instr(8'hF0, 1'b0, "halt");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("halt_hold%0d", k), obs_now(),
            mk(4'd11, 3'd0, 2'd0, 4'd0, F_NONE));
    end
    reset_to_fet1("halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spm_control_unit.md
# spm_control_unit

Finite-state sequencer for the 8-bit RISC stored-program machine. It drives the `Load_PC`/`Inc_PC` commands of the program counter and all register-load, bus-mux and memory-write strobes. It walks fetch, decode, execute and memory phases from the instruction register contents and the ALU zero flag. It sits beside the datapath and memory as the single command source for every datapath load enable.

## Interface
- No parameters; all widths are fixed by the 8-bit ISA.
- Reset `rst` is asynchronous, active-low; clock `clk`.
- Ports, one per line: name, direction, width, meaning.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-low reset.
- `instruction` in 8: IR output.
  - `[7:4]` opcode.
  - `[3:2]` src register.
  - `[1:0]` dest register.
- `zero` in 1: registered ALU zero flag (Reg_Z == 0).
- `Load_R` out 4: one-hot load enable for R3..R0.
- `Load_PC` out 1: PC parallel load.
- `Inc_PC` out 1: PC increment.
- `Load_IR` out 1: instruction register load.
- `Load_Add_R` out 1: memory address register load.
- `Load_Reg_Y` out 1: ALU operand register load.
- `Load_Reg_Z` out 1: zero-flag register load.
- `Sel_Bus_1` out 3: Bus_1 source select.
  - 0–3 select R0–R3.
  - 4 selects PC.
- `Sel_Bus_2` out 2: Bus_2 source select.
  - 0 selects ALU.
  - 1 selects Bus_1.
  - 2 selects memory word.
- `write` out 1: memory write strobe.
- `state` out 4: current state, for debug.

## Operation
- The state register is the only storage.
- All outputs are combinational from state, opcode and `zero`.
- Every output defaults to 0; `Sel_Bus_1` and `Sel_Bus_2` default to 0.
- Opcodes:
  - NOP = 0, ADD = 1, SUB = 2, AND = 3, NOT = 4.
  - RD = 5, WR = 6, BR = 7, BRZ = 8, HALT = 15.
  - 9–14 are illegal.
- States (4-bit): IDLE = 0, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT = 11.
- IDLE: no strobes → FET1.
- FET1: Sel_Bus_1 = 4, Sel_Bus_2 = 1, Load_Add_R → FET2.
- FET2: Sel_Bus_2 = 2, Load_IR, Inc_PC → DEC.
- DEC, by opcode:
  - NOP: no strobes → FET1.
  - ADD/SUB/AND: Sel_Bus_1 = src, Load_Reg_Y → EX1.
  - NOT: Sel_Bus_1 = src, Sel_Bus_2 = 0, Load_Reg_Z, Load_R[dest] → FET1.
  - RD, WR, BR: Sel_Bus_1 = 4, Sel_Bus_2 = 1, Load_Add_R → RD1, WR1 or BR1 respectively.
  - BRZ with `zero` = 1: same strobes as BR → BR1.
  - BRZ with `zero` = 0: Inc_PC only (skips the operand byte) → FET1.
  - HALT: no strobes → HALT.
- EX1: Sel_Bus_1 = dest, Sel_Bus_2 = 0, Load_Reg_Z, Load_R[dest] → FET1.
- RD1 and WR1: Sel_Bus_2 = 2, Load_Add_R, Inc_PC → RD2 or WR2 respectively.
- RD2: Sel_Bus_2 = 2, Load_R[dest] → FET1.
- WR2: Sel_Bus_1 = src, write → FET1.
- BR1: Sel_Bus_2 = 2, Load_Add_R → BR2.
- BR2: Sel_Bus_2 = 2, Load_PC → FET1.
- HALT: no strobes; stays in HALT until `rst` is asserted.
- Invariants:
  - Load_PC and Inc_PC are never 1 in the same cycle.
  - Load_R has at most one bit set.
  - `write` is never asserted together with any Load_R bit.
- Unreachable encodings 12–15 → IDLE, with no strobes.

## Timing
- `rst` low: state = IDLE, asynchronously. All outputs are 0, including `state`.
- First rising edge after release → FET1.
- Reset mid-instruction aborts immediately. No partial strobe is issued after `rst` falls.
- Instruction length in cycles, FET1 through the last state:
  - NOP/NOT/HALT: 3.
  - BRZ not taken: 3.
  - ADD/SUB/AND: 4.
  - BR, BRZ taken: 5.
  - RD and WR: 5.
- `instruction` and `zero` are sampled only in DEC, and in states that use src/dest. The IR is stable from FET2 onward.

## Configuration
- Macro: `SPM_CU_ILLEGAL_HALT_EN`.
- Defined: an illegal opcode (9–14) in DEC → HALT.
- Undefined: an illegal opcode (9–14) in DEC is executed as NOP → FET1.

## Structure
- Package `spm_pkg` holds:
  - opcode constants;
  - state encodings;
  - Bus_1 and Bus_2 select codes.
- One sub-module, `spm_opcode_decode`: combinational opcode → instruction-class flags (alu2, alu1, mem_rd, mem_wr, branch, cond, halt, illegal). The FSM uses the class flags only.

## Test plan
- Reset release: expect state IDLE, then FET1 (Load_Add_R = 1, Sel_Bus_1 = 4), then FET2 (Load_IR = 1, Inc_PC = 1).
- ADD, `instruction` = 8'h16:
  - DEC: Sel_Bus_1 = 1, Load_Reg_Y = 1.
  - EX1: Sel_Bus_1 = 2, Load_R = 4'b0100, Load_Reg_Z = 1.
  - Then back to FET1.
- BRZ, `instruction` = 8'h80:
  - `zero` = 0: Inc_PC in DEC, FET1 on the next cycle.
  - `zero` = 1: BR1 then BR2, with Load_PC = 1 in BR2.
- WR, `instruction` = 8'h6C: WR2 has Sel_Bus_1 = 3 and write = 1. Inc_PC is asserted exactly twice in the instruction.
- HALT, `instruction` = 8'hF0: all strobes 0 for 20 cycles. Then pull `rst` low in mid-cycle: state becomes 0 without a clock edge.
- Illegal opcode, `instruction` = 8'h90:
  - With the macro defined: HALT.
  - Without it: FET1.
  - Throughout every scenario, assert that Load_PC and Inc_PC are never both 1.
